// File: rtl/bsg_link_pkg.sv
// Shared definitions for the off-chip link channels: data widths, default
// credit constants and the transmit serializer state encoding.
package bsg_link_pkg;

    localparam int BEAT_W       = 8;
    localparam int HALF_W       = 16;
    localparam int WORD_W       = 32;

    // Defaults shared with the downstream receive channel.
    localparam int RX_HALFWORDS = 8;
    localparam int HW_PER_TOKEN = 4;

    // Serializer states; B0..B3 name the beat currently on the I/O bus.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_B0   = 3'd1,
        ST_B1   = 3'd2,
        ST_B2   = 3'd3,
        ST_B3   = 3'd4
    } up_state_e;

    // Byte idx of a word; beat 0 is the low byte of the low halfword.
    function automatic logic [BEAT_W-1:0] word_beat(input logic [WORD_W-1:0] w,
                                                    input logic [1:0]        idx);
        return w[idx*BEAT_W +: BEAT_W];
    endfunction

endpackage

// File: rtl/bsg_up_word_fifo.sv
// Core-side word FIFO. Push side is valid/ready, pop side is pop/empty.
// Besides the head entry it also presents the entry behind the head so the
// serializer can start the next word on the same edge that pops the current.
module bsg_up_word_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_valid,
    input  logic [WIDTH-1:0]           push_data,
    output logic                       push_ready,
    input  logic                       pop,
    output logic                       empty,
    output logic [WIDTH-1:0]           head_data,
    output logic [WIDTH-1:0]           next_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW-1:0]    rd_idx_nxt;
    logic             full;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB tells full (MSBs differ, index equal) from empty.
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty      = (wr_ptr == rd_ptr);
    assign push_ready = !full;
    assign do_push    = push_valid && push_ready;
    assign do_pop     = pop && !empty;
    assign count      = wr_ptr - rd_ptr;
    assign rd_idx_nxt = rd_ptr[AW-1:0] + AW'(1);
    assign head_data  = mem[rd_ptr[AW-1:0]];
    assign next_data  = mem[rd_idx_nxt];

    // Storage array; contents need no reset since pointers gate every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    // Read and write pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/bsg_upstream_ch.sv
// Transmit-side link channel: buffers 32-bit core words and sends each as four
// byte beats, paced by halfword credits returned as toggles on io_token_in.
// Handshake: the core side transfers a word on any rising clk edge where
// core_valid_in and core_ready_out are both high; core_ready_out depends only
// on registered state. The I/O side has no back-pressure: a beat is delivered
// on every cycle io_valid_out is high.
module bsg_upstream_ch #(
    parameter int FIFO_WORDS   = 4,
    parameter int RX_HALFWORDS = bsg_link_pkg::RX_HALFWORDS,
    parameter int HW_PER_TOKEN = bsg_link_pkg::HW_PER_TOKEN
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          core_valid_in,
    input  logic [31:0]                   core_data_in,
    output logic                          core_ready_out,
    output logic                          io_valid_out,
    output logic [7:0]                    io_data_out,
    input  logic                          io_token_in,
    output logic                          credit_err,
    output logic [2:0]                    dbg_state,
    output logic [$clog2(RX_HALFWORDS):0] dbg_credits
);

    import bsg_link_pkg::*;

    localparam int CW  = $clog2(RX_HALFWORDS) + 1;
    localparam int FPW = $clog2(FIFO_WORDS) + 1;
    localparam int SW  = $clog2(RX_HALFWORDS + HW_PER_TOKEN + 1) + 1;

    up_state_e          state;
    up_state_e          state_nxt;
    logic               tok_q1;
    logic               tok_q2;
    logic               tok_q3;
    logic               tok_edge;
    logic [CW-1:0]      credits;
    logic [SW-1:0]      credit_sum;
    logic               credit_ovf;
    logic               hw_start;
    logic               fifo_pop;
    logic               fifo_empty;
    logic [FPW-1:0]     fifo_count;
    logic [WORD_W-1:0]  head_word;
    logic [WORD_W-1:0]  next_word;
    logic               valid_nxt;
    logic [BEAT_W-1:0]  data_nxt;

    bsg_up_word_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_WORDS)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (core_valid_in),
        .push_data  (core_data_in),
        .push_ready (core_ready_out),
        .pop        (fifo_pop),
        .empty      (fifo_empty),
        .head_data  (head_word),
        .next_data  (next_word),
        .count      (fifo_count)
    );

    // Token synchronizer plus one delay stage for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tok_q1 <= 1'b0;
            tok_q2 <= 1'b0;
            tok_q3 <= 1'b0;
        end else begin
            tok_q1 <= io_token_in;
            tok_q2 <= tok_q1;
            tok_q3 <= tok_q2;
        end
    end

    assign tok_edge = tok_q2 ^ tok_q3;

    // Net credit change this cycle, computed wide enough to see overflow.
    always_comb begin
        credit_sum = SW'(credits);
        if (tok_edge) credit_sum = credit_sum + SW'(HW_PER_TOKEN);
        if (hw_start) credit_sum = credit_sum - SW'(1);
        credit_ovf = (credit_sum > SW'(RX_HALFWORDS));
    end

    // Credit counter saturates at receiver capacity; overflow is sticky.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credits    <= CW'(RX_HALFWORDS);
            credit_err <= 1'b0;
        end else if (credit_ovf) begin
            credits    <= CW'(RX_HALFWORDS);
            credit_err <= 1'b1;
        end else begin
            credits    <= credit_sum[CW-1:0];
        end
    end

    // Serializer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and next beat; a halfword only starts with a credit in hand,
    // so its second byte always follows on the next cycle.
    always_comb begin
        state_nxt = state;
        hw_start  = 1'b0;
        fifo_pop  = 1'b0;
        valid_nxt = 1'b0;
        data_nxt  = io_data_out;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty && credits != '0) begin
                    state_nxt = ST_B0;
                    hw_start  = 1'b1;
                    valid_nxt = 1'b1;
                    data_nxt  = word_beat(head_word, 2'd0);
                end
            end
            ST_B0: begin
                state_nxt = ST_B1;
                valid_nxt = 1'b1;
                data_nxt  = word_beat(head_word, 2'd1);
            end
            ST_B1: begin
                // Holding here with valid low is the mid-word credit stall.
                if (credits != '0 || tok_edge) begin
                    state_nxt = ST_B2;
                    hw_start  = 1'b1;
                    valid_nxt = 1'b1;
                    data_nxt  = word_beat(head_word, 2'd2);
                end
            end
            ST_B2: begin
                state_nxt = ST_B3;
                valid_nxt = 1'b1;
                data_nxt  = word_beat(head_word, 2'd3);
            end
            ST_B3: begin
                fifo_pop = 1'b1;
                if (fifo_count > FPW'(1) && credits != '0) begin
                    state_nxt = ST_B0;
                    hw_start  = 1'b1;
                    valid_nxt = 1'b1;
                    data_nxt  = word_beat(next_word, 2'd0);
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Registered I/O beat; data holds its last value while the bus idles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            io_valid_out <= 1'b0;
            io_data_out  <= '0;
        end else begin
            io_valid_out <= valid_nxt;
            io_data_out  <= data_nxt;
        end
    end

    assign dbg_state   = state;
    assign dbg_credits = credits;

endmodule

// File: tb/tb_bsg_upstream_ch.sv
// Directed bench for bsg_upstream_ch with a beat scoreboard.
module tb_bsg_upstream_ch;

    import bsg_link_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        core_valid_in;
    logic [31:0] core_data_in;
    logic        core_ready_out;
    logic        io_valid_out;
    logic [7:0]  io_data_out;
    logic        io_token_in;
    logic        credit_err;
    logic [2:0]  dbg_state;
    logic [3:0]  dbg_credits;

    logic [7:0]  exp_q[$];
    int          beat_cyc[$];
    int          checks;
    int          failures;
    int          cyc;
    int          acc;
    logic        rdy;

    bsg_upstream_ch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .core_valid_in  (core_valid_in),
        .core_data_in   (core_data_in),
        .core_ready_out (core_ready_out),
        .io_valid_out   (io_valid_out),
        .io_data_out    (io_data_out),
        .io_token_in    (io_token_in),
        .credit_err     (credit_err),
        .dbg_state      (dbg_state),
        .dbg_credits    (dbg_credits)
    );

    // Clock and cycle counter.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: every valid beat must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && io_valid_out === 1'b1) begin
            chk("beat_expected_avail", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                chk("beat_data", 32'(io_data_out), 32'(exp_q.pop_front()));
            end
            beat_cyc.push_back(cyc);
        end
    end

    // Step to the middle of the low clock phase, after the monitor has run.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] w);
        for (int k = 0; k < 4; k++) exp_q.push_back(w[k*8 +: 8]);
    endtask

    task automatic push_word(input logic [31:0] w);
        int n;
        n = 0;
        core_valid_in = 1'b1;
        core_data_in  = w;
        while (!core_ready_out && n < 50) begin
            tick();
            n++;
        end
        if (!core_ready_out) begin
            chk("push_timeout", 32'(core_ready_out), 32'd1);
        end else begin
            @(posedge clk);
            push_exp(w);
        end
        tick();
        core_valid_in = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && dbg_state == 3'(ST_IDLE) && !io_valid_out) && n < 100) begin
            tick();
            n++;
        end
        chk("drain_done", 32'(exp_q.size() == 0 && dbg_state == 3'(ST_IDLE)), 32'd1);
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        core_valid_in = 1'b0;
        core_data_in  = '0;
        io_token_in   = 1'b0;
        exp_q.delete();
        beat_cyc.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int n;
        checks        = 0;
        failures      = 0;
        cyc           = 0;
        rst_n         = 1'b0;
        core_valid_in = 1'b0;
        core_data_in  = '0;
        io_token_in   = 1'b0;

        // Reset values.
        tick();
        chk("rst_valid", 32'(io_valid_out), 32'd0);
        chk("rst_data", 32'(io_data_out), 32'd0);
        chk("rst_ready", 32'(core_ready_out), 32'd1);
        chk("rst_err", 32'(credit_err), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        chk("rst_credits", 32'(dbg_credits), 32'd8);

        // Single word: four beats on consecutive cycles one cycle after accept.
        do_reset();
        push_word(32'hDDCCBBAA);
        chk("lat_accept_cycle", 32'(io_valid_out), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("single_beat_valid", 32'(io_valid_out), 32'd1);
        end
        tick();
        chk("single_after_valid", 32'(io_valid_out), 32'd0);
        chk("single_credits", 32'(dbg_credits), 32'd6);
        chk("single_q_empty", 32'(exp_q.size()), 32'd0);

        // Credit exhaustion: five words, no tokens.
        do_reset();
        for (int i = 0; i < 5; i++) push_word($urandom);
        repeat (40) tick();
        chk("exh_beats", 32'(beat_cyc.size()), 32'd16);
        if (beat_cyc.size() >= 16) chk("exh_span", 32'(beat_cyc[15] - beat_cyc[0]), 32'd15);
        chk("exh_valid", 32'(io_valid_out), 32'd0);
        chk("exh_credits", 32'(dbg_credits), 32'd0);
        chk("exh_fifo_count", 32'(dut.fifo_count), 32'd1);
        chk("exh_q_left", 32'(exp_q.size()), 32'd4);

        // Token return: visible three cycles later, then the fifth word.
        io_token_in = ~io_token_in;
        tick();
        tick();
        chk("tok_not_yet", 32'(dbg_credits), 32'd0);
        tick();
        chk("tok_credits", 32'(dbg_credits), 32'd4);
        chk("tok_valid_pre", 32'(io_valid_out), 32'd0);
        wait_drain();
        chk("tok_beats", 32'(beat_cyc.size()), 32'd20);
        if (beat_cyc.size() >= 20) chk("tok_span", 32'(beat_cyc[19] - beat_cyc[16]), 32'd3);
        chk("tok_credits_end", 32'(dbg_credits), 32'd2);

        // Mid-word stall: an overflowing token mid-word leaves an odd count.
        do_reset();
        io_token_in = ~io_token_in;
        push_word(32'h44332211);
        wait_drain();
        chk("odd_credits", 32'(dbg_credits), 32'd7);
        chk("odd_err", 32'(credit_err), 32'd1);
        for (int i = 0; i < 3; i++) push_word($urandom);
        wait_drain();
        chk("stall_pre_credits", 32'(dbg_credits), 32'd1);
        push_word(32'hDDCCBBAA);
        repeat (8) tick();
        chk("stall_valid", 32'(io_valid_out), 32'd0);
        chk("stall_state", 32'(dbg_state), 32'(ST_B1));
        chk("stall_credits", 32'(dbg_credits), 32'd0);
        chk("stall_q_left", 32'(exp_q.size()), 32'd2);
        chk("stall_data_hold", 32'(io_data_out), 32'hBB);
        io_token_in = ~io_token_in;
        n = 0;
        while (!io_valid_out && n < 10) begin
            tick();
            n++;
        end
        chk("resume_valid", 32'(io_valid_out), 32'd1);
        chk("resume_cc", 32'(io_data_out), 32'hCC);
        tick();
        chk("resume_dd_valid", 32'(io_valid_out), 32'd1);
        chk("resume_dd", 32'(io_data_out), 32'hDD);
        tick();
        chk("resume_idle", 32'(io_valid_out), 32'd0);
        chk("resume_data_hold", 32'(io_data_out), 32'hDD);
        if (beat_cyc.size() >= 20) begin
            chk("stall_ab_pair", 32'(beat_cyc[17] - beat_cyc[16]), 32'd1);
            chk("stall_cd_pair", 32'(beat_cyc[19] - beat_cyc[18]), 32'd1);
            chk("stall_gap", 32'((beat_cyc[18] - beat_cyc[17]) > 1), 32'd1);
        end

        // FIFO full with no credits, then a pop while full.
        do_reset();
        for (int i = 0; i < 4; i++) push_word($urandom);
        wait_drain();
        chk("full_pre_credits", 32'(dbg_credits), 32'd0);
        acc = 0;
        core_valid_in = 1'b1;
        core_data_in  = $urandom;
        for (int i = 0; i < 8; i++) begin
            rdy = core_ready_out;
            @(posedge clk);
            if (rdy) begin
                push_exp(core_data_in);
                acc++;
            end
            tick();
            if (rdy) core_data_in = $urandom;
        end
        chk("full_accepted", 32'(acc), 32'd4);
        chk("full_ready", 32'(core_ready_out), 32'd0);
        io_token_in = ~io_token_in;
        n = 0;
        while (dbg_state != 3'(ST_B3) && n < 20) begin
            tick();
            n++;
        end
        chk("full_reach_b3", 32'(dbg_state), 32'(ST_B3));
        chk("full_ready_on_pop", 32'(core_ready_out), 32'd0);
        chk("full_count_on_pop", 32'(dut.fifo_count), 32'd4);
        tick();
        chk("full_count_after_pop", 32'(dut.fifo_count), 32'd3);
        chk("full_ready_after_pop", 32'(core_ready_out), 32'd1);
        @(posedge clk);
        push_exp(core_data_in);
        tick();
        core_valid_in = 1'b0;
        chk("full_refill", 32'(dut.fifo_count), 32'd4);
        repeat (20) tick();
        chk("full_q_left", 32'(exp_q.size()), 32'd12);
        chk("full_credits_end", 32'(dbg_credits), 32'd0);

        // Overflow at full credits, then asynchronous reset mid-word.
        do_reset();
        io_token_in = ~io_token_in;
        tick();
        tick();
        tick();
        chk("ovf_err", 32'(credit_err), 32'd1);
        chk("ovf_credits", 32'(dbg_credits), 32'd8);
        push_word(32'h12345678);
        @(posedge clk);
        #2;
        chk("pre_rst_valid", 32'(io_valid_out), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(io_valid_out), 32'd0);
        chk("async_rst_err", 32'(credit_err), 32'd0);
        chk("async_rst_credits", 32'(dbg_credits), 32'd8);
        chk("async_rst_state", 32'(dbg_state), 32'(ST_IDLE));
        exp_q.delete();
        io_token_in = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (6) tick();
        chk("discard_valid", 32'(io_valid_out), 32'd0);
        chk("discard_ready", 32'(core_ready_out), 32'd1);
        chk("discard_count", 32'(dut.fifo_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
